// File: rtl/g2_sched_ctrl.sv
// g2_sched_ctrl: sequences one g2 accumulation run (a1/a2 pacing, event count, histogram readout)
// Ports:
//   clk, RST (async active-low)    clock and reset
//   start, frames                  run request and number of a1 events in the run
//   a1V, a2V, unitFV               buffer/window valid and processing-unit result valid
//   next                           one-cycle advance strobe to the a1/a2 buffers
//   g2Rst                          histogram readout control; a falling edge starts readout
//   g2V, g2R                       histogram word handshake, observed only
//   busy, done, evCnt              run status, completion pulse, events completed
module g2_sched_ctrl #(
    parameter int cycleBit = 1,
    parameter int addrBit  = 9,
    parameter int frameBit = 15
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [frameBit:0] frames,
    input  logic              a1V,
    input  logic              a2V,
    input  logic              unitFV,
    output logic              next,
    output logic              g2Rst,
    input  logic              g2V,
    input  logic              g2R,
    output logic              busy,
    output logic              done,
    output logic [frameBit:0] evCnt
);
    typedef enum logic [2:0] {IDLE, WAIT_DATA, ISSUE, WAIT_FV, FLUSH, READOUT, DONE} state_t;
    // last word index before the terminal count; wCnt keeps one extra bit so it never wraps
    localparam logic [addrBit+1:0] W_LAST = {1'b0, {(addrBit+1){1'b1}}};
    state_t              state;
    logic [cycleBit:0]   cyc;
    logic [addrBit+1:0]  wCnt;
    logic [frameBit:0]   frmReg;
    logic [frameBit:0]   ev_nxt;
    logic                fl;
    assign ev_nxt = evCnt + 1'b1;
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            next   <= 1'b0;
            g2Rst  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            evCnt  <= '0;
            cyc    <= '0;
            wCnt   <= '0;
            frmReg <= '0;
            fl     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    frmReg <= frames;
                    evCnt  <= '0;
                    cyc    <= '0;
                    busy   <= 1'b1;
                    if (frames == '0) begin
                        state <= FLUSH;
                        g2Rst <= 1'b0;
                        fl    <= 1'b0;
                    end else begin
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: if (a1V && a2V && cyc == '0) begin
                    state <= ISSUE;
                    next  <= 1'b1;
                end
                ISSUE: begin
                    next  <= 1'b0;
                    cyc   <= cyc + 1'b1;
                    state <= WAIT_FV;
                end
                // a wrapped cycle counter marks the end of an event; otherwise the event continues unchecked
                WAIT_FV: if (unitFV) begin
                    if (cyc != '0) begin
                        state <= ISSUE;
                        next  <= 1'b1;
                    end else begin
                        evCnt <= ev_nxt;
                        if (ev_nxt == frmReg) begin
                            state <= FLUSH;
                            g2Rst <= 1'b0;
                            fl    <= 1'b0;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                // g2Rst stays low for two cycles: fl marks the second one
                FLUSH: begin
                    fl <= 1'b1;
                    if (fl) begin
                        g2Rst <= 1'b1;
                        wCnt  <= '0;
                        state <= READOUT;
                    end
                end
                READOUT: if (g2V && g2R) begin
                    wCnt <= wCnt + 1'b1;
                    if (wCnt == W_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/g2_sched_ctrl.md
# g2_sched_ctrl

Sequencing controller for the g2 correlation datapath. Runs one accumulation run: it paces the a1/a2 sample buffers through their correlation cycles with single-cycle `next` strobes, counts processed a1 events, and starts the g2 histogram readout with a falling edge on the histogram memory's readout input. It then counts the drained histogram words and signals completion. It sits between the host/start logic and the a1/a2/g2 memory wrappers.

## Interface
- `cycleBit`, default 1: cycle counter width minus 1. One event spans 2^(cycleBit+1) cycles (4 by default).
- `addrBit`, default 9: histogram address width minus 1. Readout drains 2^(addrBit+1) words (1024 by default).
- `frameBit`, default 15: event-count width minus 1.
- `clk`, in, 1: the single clock.
- `RST`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: pulse that begins a run. Ignored while `busy`.
- `frames`, in, frameBit+1: number of a1 events per run. Sampled when `start` is accepted.
- `a1V`, in, 1: a1 buffer output valid.
- `a2V`, in, 1: a2 buffer full window valid.
- `unitFV`, in, 1: processing-unit flags valid, meaning the current cycle's result is done.
- `next`, out, 1: one-cycle advance strobe to the a1 and a2 buffers.
- `g2Rst`, out, 1: drives the histogram readout input. Idles high; a falling edge starts readout.
- `g2V`, in, 1: histogram word valid, observed only.
- `g2R`, in, 1: histogram word accepted by the sink, observed only.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when readout completes.
- `evCnt`, out, frameBit+1: events completed in the current run.

## Operation
- States: IDLE, WAIT_DATA, ISSUE, WAIT_FV, FLUSH, READOUT, DONE.
- IDLE:
  - On `start`, latch `frames` into `frmReg`, clear `evCnt` and `cyc`.
  - Go to WAIT_DATA, or to FLUSH if `frames`==0.
- WAIT_DATA: when `a1V && a2V`, go to ISSUE. The window is checked only at `cyc`==0.
- ISSUE: lasts exactly one cycle. `next`=1, `cyc`←`cyc`+1 (wraps mod 2^(cycleBit+1)). Go to WAIT_FV.
- WAIT_FV: `next`=0. Wait for `unitFV`=1, then:
  - If `cyc`!=0, go to ISSUE. The same event continues with no re-check of valid inputs.
  - If `cyc`==0, the event is complete: `evCnt`←`evCnt`+1.
  - If the new `evCnt`==`frmReg`, go to FLUSH; otherwise go to WAIT_DATA.
- FLUSH: `g2Rst`=0 for exactly 2 cycles, then high again. Clear the word counter `wCnt` and go to READOUT.
- READOUT:
  - `wCnt`←`wCnt`+1 on each cycle with `g2V && g2R`.
  - After the 2^(addrBit+1)-th handshake, go to DONE.
  - `wCnt` is addrBit+2 bits wide, so the terminal count does not wrap.
- DONE: `done`=1 for one cycle, then IDLE. `evCnt` holds its value until the next `start`.
- `unitFV` is ignored outside WAIT_FV. `g2V`/`g2R` are ignored outside READOUT.
- `start` pulses outside IDLE are dropped, not queued.
- Async `RST`=0 at any time, including mid-cycle or mid-readout:
  - Go to IDLE. `next`=0, `g2Rst`=1, `busy`=0, `done`=0.
  - `evCnt`=0, `cyc`=0, `wCnt`=0, `frmReg`=0.
  - No `next` or `g2Rst` edge is emitted on reset release.

## Timing
- All outputs are registered. They reflect the state entered at the prior rising edge.
- `start` sampled at edge t:
  - `busy`=1 from t+1.
  - If `a1V&&a2V` is already high at t+1, `next` is high during t+2 to t+3.
- Minimum spacing between `next` pulses is 2 cycles (ISSUE → WAIT_FV with `unitFV` already high → ISSUE).
- `unitFV` sampled high at edge e in WAIT_FV gives:
  - the next ISSUE at e+1, or
  - the `evCnt` update visible at e+1.
- FLUSH entered at edge f:
  - `g2Rst` is low during [f, f+2), high from f+2.
  - READOUT from f+2.
- Handshakes in the same cycle as the FLUSH→READOUT transition are not counted.
- The last counted handshake at edge h gives `done`=1 during [h+1, h+2), and `busy`=0 from h+2.

## Test plan
- Reset behaviour: `RST` low then released, no stimulus → `next`=0, `g2Rst`=1, `busy`=0, `done`=0, `evCnt`=0 for 20 cycles.
- Single event: `frames`=1, `a1V`=`a2V`=1, `unitFV` held high → 4 `next` pulses each 2 cycles apart, `evCnt`=1, `g2Rst` low for 2 cycles. Then 1024 `g2V&&g2R` handshakes → one `done` pulse, `busy` drops.
- Data stall: `frames`=3, with `a2V` deasserted for 10 cycles after event 1 → no `next` while `a2V`=0 at `cyc`==0, and `evCnt` ends at 3.
- Readout backpressure: `g2R` toggles every other cycle during READOUT → `done` only after exactly 1024 accepted words. Idle `g2V` cycles are not counted.
- `frames`=0 → no `next`, FLUSH immediately after `start`, full readout, `done`.
- Mid-run reset: `RST` pulsed low during WAIT_FV of event 2, then `start` again with `frames`=2 → the first run aborts cleanly, and the second run completes with `evCnt`=2 and exactly 8 `next` pulses.
